// File: rtl/i2s_pkg.sv
// i2s_pkg: shared widths, sample/frame types and the frame builder for the I2S transmitter.
// Contents: SAMPLE_W, SLOT_W, FRAME_BITS, sample_t, frame_t, build_frame().
// No logic state; build_frame is a pure combinational helper.
package i2s_pkg;

    localparam int SAMPLE_W   = 24;
    localparam int SLOT_W     = 32;
    localparam int FRAME_BITS = 64;

    typedef logic [SAMPLE_W-1:0]   sample_t;
    typedef logic [FRAME_BITS-1:0] frame_t;

    // Philips framing: each slot starts one BCLK late, so the leading zero
    // of the left slot pushes the left pad down to 8 bits and the right
    // slot's leading zero is the last bit of that pad; the right pad is 7.
    function automatic frame_t build_frame(input sample_t l, input sample_t r, input logic mute);
        frame_t f;
        if (mute) begin
            f = '0;
        end else begin
            f = {1'b0, l, {(SLOT_W-SAMPLE_W){1'b0}}, r, {(SLOT_W-SAMPLE_W-1){1'b0}}};
        end
        return f;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides clk down to the I2S bit clock and flags each falling edge.
// Latency: bclk toggles every CLK_DIV clks; fall_tick is high in the clk cycle whose edge drops bclk.
// No backpressure; free-running from reset release. Ports: clk, rst_n in; bclk, fall_tick out.
module i2s_bclk_gen #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    output logic bclk,
    output logic fall_tick
);

    logic [7:0] div_cnt;
    logic       wrap;

    assign wrap = (div_cnt == 8'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= 8'd0;
            bclk    <= 1'b0;
        end else if (wrap) begin
            div_cnt <= 8'd0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    // Decoded from registered state so the consumer's registers move on the
    // very edge that drops bclk.
    assign fall_tick = wrap & bclk;

endmodule

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: serialises stereo 24-bit samples into a Philips I2S stream (bclk, lrck, dacdat).
// Latency: samples captured at the frame boundary (sample_req), L MSB on dacdat one BCLK later.
// No backpressure: inputs are sampled only on the sample_req cycle and must be valid then.
// Ports: clk, rst_n, sample_l, sample_r, mute in; sample_req, bclk, lrck, dacdat out.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    input  sample_t sample_l,
    input  sample_t sample_r,
    input  logic    mute,
    output logic    sample_req,
    output logic    bclk,
    output logic    lrck,
    output logic    dacdat
);

    logic       fall_tick;
    logic [5:0] bit_pos;
    frame_t     shift;

    i2s_bclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bclk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .bclk      (bclk),
        .fall_tick (fall_tick)
    );

    // bit_pos resets to 63 so the first fall event is a frame boundary and
    // loads a fresh frame; nothing from an interrupted frame survives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_pos    <= 6'd63;
            shift      <= '0;
            sample_req <= 1'b0;
        end else begin
            sample_req <= 1'b0;
            if (fall_tick) begin
                bit_pos <= bit_pos + 6'd1;
                if (bit_pos == 6'd63) begin
                    shift      <= build_frame(sample_l, sample_r, mute);
                    sample_req <= 1'b1;
                end else begin
                    shift <= {shift[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

    // Both are direct register bits, so they only move on fall events.
    assign lrck   = bit_pos[5];
    assign dacdat = shift[FRAME_BITS-1];

endmodule
